pipelined_shift_unit: RTL and testbench
=======================================

# pipelined_shift_unit

Parametrised, two-stage pipelined shift/rotate unit for the KGP_RISC execute stage. It supersedes the single-mode 32-bit arithmetic right shifter and supports logical left, logical right, arithmetic right and (optionally) rotate operations. Operand width is configurable, and shift amounts at or beyond the width saturate. Operands enter and results leave on valid/ready handshakes. Results carry zero and carry-out flags for the ALU flag logic.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥8
- SHW, $clog2(WIDTH), number of shift levels (derived, not overridden)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- in_data  input  WIDTH  operand A (treated as signed for SRA)
- in_shamt  input  WIDTH  shift amount, full register width
- in_mode  input  3  operation code (see Operation)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  shifted result
- out_carry  output  1  last bit shifted out
- out_zero  output  1  out_data == 0
- out_err  output  1  illegal mode; out_data forced to 0

## Operation
- Modes: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR. Codes 101–111 are illegal.
- Effective amount:
  - Rotates use in_shamt mod WIDTH.
  - Other modes: if in_shamt ≥ WIDTH, SLL/SRL give 0 and SRA gives all copies of A[WIDTH-1].
- out_carry:
  - SLL: A[WIDTH-s]
  - SRL/SRA: A[s-1]
  - ROL: result[0]
  - ROR: result[WIDTH-1]
  - Effective s = 0 gives 0.
  - Saturated case: 0 for SLL/SRL, A[WIDTH-1] for SRA.
- Illegal mode: out_data = 0, out_carry = 0, out_zero = 1, out_err = 1. The beat still flows through the pipeline normally.
- Stage 1 applies shift levels SHW-1 down to SHW/2 and registers the partial result, residual shamt, mode and saturation/illegal decode.
- Stage 2 applies the remaining levels, computes the flags, and registers the outputs.

## Timing
- Latency is 2 cycles from an accepted input beat (in_valid && in_ready) to out_valid, when there is no backpressure.
- Throughput is 1 beat per cycle.
- Each stage register loads when it is empty or its contents move downstream this cycle, so bubbles collapse.
- in_ready = !s1_valid || s1_advance. It is purely a function of state and out_ready and does not depend on in_valid.
- While out_valid && !out_ready:
  - out_data and all flags stay stable.
  - Stage 1 holds if full.
  - in_ready drops once both stages are full.
- Simultaneous accept on the input and drain on the output in one cycle is legal, with no lost or duplicated beats.
- Reset:
  - All valids are 0 and out_data, out_carry, out_zero, out_err are 0. in_ready is 1 in the first cycle after rst_n rises.
  - rst_n low mid-operation discards all in-flight beats in the same edge.
- Outputs come directly from stage 2 registers, with no combinational path from in_* to out_*.

## Configuration
- SHIFT_ROTATE_EN defined: ROL/ROR are legal and the rotate datapath is instantiated.
- SHIFT_ROTATE_EN undefined: codes 011/100 are illegal, with the same behaviour as 101–111 (out_err = 1, data 0). The rotate logic is removed from both stages.

## Structure
- Package kgp_shift_pkg holds:
  - the shift_mode_t enum (SLL, SRL, SRA, ROL, ROR)
  - the MODE_W = 3 constant
  - an is_legal_mode() function, with the rotate legality guarded by SHIFT_ROTATE_EN
- Sub-module shift_levels: combinational, parametrised by WIDTH, LO and HI level indices.
  - Applies levels HI..LO for the given mode.
  - Instantiated once per pipeline stage.
- Top module: handshake/stage registers, saturation decode and flag generation.

## Test plan
- SRA 0x80000000 by 4 → 0xF8000000, carry 0, zero 0, latency exactly 2 cycles.
- SRL 0x0000000F by 2 → 0x00000003, carry 1. SLL 0x80000001 by 1 → 0x00000002, carry 1.
- Saturation:
  - SRA 0x80000000 by 40 → 0xFFFFFFFF, carry 1.
  - SLL 0x12345678 by 32 → 0x00000000, zero 1, carry 0.
- Rotate:
  - With SHIFT_ROTATE_EN, ROR 0x00000001 by 33 → 0x80000000, carry 1.
  - Without it, the same beat → 0, err 1, zero 1. Mode 111 → err 1 in both builds.
- Backpressure:
  - Stream 6 beats with out_ready low on cycles 3–6.
  - in_ready deasserts with both stages full.
  - out_data is held stable while stalled.
  - All 6 results arrive in order with no loss or duplication.
- Assert rst_n low with 2 beats in flight → next cycle out_valid 0, all outputs 0, in_ready 1, and no stale results after release.

Source files
------------

// File: rtl/kgp_shift_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kgp_shift_pkg : mode codes and legality decode for pipelined_shift_unit.
// Option macro SHIFT_ROTATE_EN makes ROL/ROR legal.  Rev 1.0
// ---------------------------------------------------------------------------
package kgp_shift_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    SLL = 3'b000,
    SRL = 3'b001,
    SRA = 3'b010,
    ROL = 3'b011,
    ROR = 3'b100
  } shift_mode_t;

  function automatic logic is_legal_mode(input logic [MODE_W-1:0] mode);
    logic legal;
    legal = (mode == SLL) || (mode == SRL) || (mode == SRA);
`ifdef SHIFT_ROTATE_EN
    legal = legal || (mode == ROL) || (mode == ROR);
`endif
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_shift_unit_levels.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_levels : combinational log-shifter slice applying levels HI..LO.
// Option macro SHIFT_ROTATE_EN adds the rotate datapath.  Rev 1.0
// ---------------------------------------------------------------------------
module shift_levels
  import kgp_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LO    = 0,
  parameter int HI    = 0
) (
  input  logic [WIDTH-1:0]  data_i,
  input  logic              carry_i,
  input  logic [HI:LO]      shamt_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              carry_o
);

  logic [WIDTH-1:0] lvl_data  [LO:HI+1];
  logic             lvl_carry [LO:HI+1];

  assign lvl_data[HI+1]  = data_i;
  assign lvl_carry[HI+1] = carry_i;

  // Carry tracks the last bit dropped by the most recently applied level;
  // since the levels compose, that equals the bit dropped by the full shift.
  for (genvar l = HI; l >= LO; l--) begin : g_lvl
    localparam int K = 1 << l;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             c_out;

    assign d_in = lvl_data[l+1];

    always_comb begin
      d_out = d_in;
      c_out = lvl_carry[l+1];
      if (shamt_i[l]) begin
        case (mode_i)
          SLL: begin
            d_out = d_in << K;
            c_out = d_in[WIDTH-K];
          end
          SRL: begin
            d_out = d_in >> K;
            c_out = d_in[K-1];
          end
          SRA: begin
            d_out = $unsigned($signed(d_in) >>> K);
            c_out = d_in[K-1];
          end
`ifdef SHIFT_ROTATE_EN
          ROL: d_out = (d_in << K) | (d_in >> (WIDTH-K));
          ROR: d_out = (d_in >> K) | (d_in << (WIDTH-K));
`endif
          default: ;
        endcase
      end
    end

    assign lvl_data[l]  = d_out;
    assign lvl_carry[l] = c_out;
  end

  assign data_o  = lvl_data[LO];
  assign carry_o = lvl_carry[LO];

endmodule
`default_nettype wire

// File: rtl/pipelined_shift_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_shift_unit : two-stage valid/ready shift/rotate unit with flags.
// Option macro SHIFT_ROTATE_EN enables ROL/ROR.  Rev 1.0
// ---------------------------------------------------------------------------
module pipelined_shift_unit
  import kgp_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [WIDTH-1:0]  in_shamt,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_err
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int S1_LO = SHW / 2;

  // Stage 1 decode and upper shift levels
  logic             err_1;
  logic             sat_1;
  logic [WIDTH-1:0] data_1;
  logic             carry_1;

  assign err_1 = !is_legal_mode(in_mode);

`ifdef SHIFT_ROTATE_EN
  logic rot_1;
  logic nz_1;
  assign rot_1 = (in_mode == ROL) || (in_mode == ROR);
  assign nz_1  = |in_shamt[SHW-1:0];
  assign sat_1 = !rot_1 && (|in_shamt[WIDTH-1:SHW]);
`else
  assign sat_1 = |in_shamt[WIDTH-1:SHW];
`endif

  shift_levels #(
    .WIDTH (WIDTH),
    .LO    (S1_LO),
    .HI    (SHW-1)
  ) u_stage1 (
    .data_i  (in_data),
    .carry_i (1'b0),
    .shamt_i (in_shamt[SHW-1:S1_LO]),
    .mode_i  (in_mode),
    .data_o  (data_1),
    .carry_o (carry_1)
  );

  logic              s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]  s1_data_q;
  logic              s1_carry_q;
  logic [S1_LO-1:0]  s1_shamt_q;
  logic [MODE_W-1:0] s1_mode_q;
  logic              s1_sat_q;
  logic              s1_err_q;
`ifdef SHIFT_ROTATE_EN
  logic              s1_rot_q;
  logic              s1_nz_q;
`endif

  // Stage 2 lower levels and flag generation
  logic [WIDTH-1:0] data_2;
  logic             carry_2;

  shift_levels #(
    .WIDTH (WIDTH),
    .LO    (0),
    .HI    (S1_LO-1)
  ) u_stage2 (
    .data_i  (s1_data_q),
    .carry_i (s1_carry_q),
    .shamt_i (s1_shamt_q),
    .mode_i  (s1_mode_q),
    .data_o  (data_2),
    .carry_o (carry_2)
  );

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_carry_q, out_carry_d;
  logic             out_zero_q, out_zero_d;
  logic             out_err_q;

  always_comb begin
    out_data_d  = data_2;
    out_carry_d = carry_2;
    if (s1_err_q) begin
      out_data_d  = '0;
      out_carry_d = 1'b0;
    end
`ifdef SHIFT_ROTATE_EN
    else if (s1_rot_q) begin
      if (!s1_nz_q)
        out_carry_d = 1'b0;
      else if (s1_mode_q == ROL)
        out_carry_d = data_2[0];
      else
        out_carry_d = data_2[WIDTH-1];
    end
`endif
    else if (s1_sat_q) begin
      // An arithmetic partial shift keeps the operand sign in the MSB.
      if (s1_mode_q == SRA) begin
        out_data_d  = {WIDTH{s1_data_q[WIDTH-1]}};
        out_carry_d = s1_data_q[WIDTH-1];
      end else begin
        out_data_d  = '0;
        out_carry_d = 1'b0;
      end
    end
    out_zero_d = (out_data_d == '0);
  end

  // Handshake: each stage loads when empty or when its beat moves on.
  logic s2_open;
  logic s1_advance;

  assign s2_open     = !out_valid_q || out_ready;
  assign s1_advance  = s1_valid_q && s2_open;
  assign in_ready    = !s1_valid_q || s1_advance;
  assign s1_valid_d  = in_ready ? in_valid : s1_valid_q;
  assign out_valid_d = s2_open ? s1_valid_q : out_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_carry_q  <= 1'b0;
      s1_shamt_q  <= '0;
      s1_mode_q   <= '0;
      s1_sat_q    <= 1'b0;
      s1_err_q    <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      s1_rot_q    <= 1'b0;
      s1_nz_q     <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (in_ready && in_valid) begin
        s1_data_q  <= data_1;
        s1_carry_q <= carry_1;
        s1_shamt_q <= in_shamt[S1_LO-1:0];
        s1_mode_q  <= in_mode;
        s1_sat_q   <= sat_1;
        s1_err_q   <= err_1;
`ifdef SHIFT_ROTATE_EN
        s1_rot_q   <= rot_1;
        s1_nz_q    <= nz_1;
`endif
      end
      if (s1_advance) begin
        out_data_q  <= out_data_d;
        out_carry_q <= out_carry_d;
        out_zero_q  <= out_zero_d;
        out_err_q   <= s1_err_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign out_zero  = out_zero_q;
  assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shift_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipelined_shift_unit : directed vectors against a bit-serial reference.
// Honours SHIFT_ROTATE_EN the same way as the design.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipelined_shift_unit;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [31:0] in_data   = '0;
  logic [31:0] in_shamt  = '0;
  logic [2:0]  in_mode   = '0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_carry;
  logic        out_zero;
  logic        out_err;

  pipelined_shift_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];

  // Reference: shifts one bit position at a time, carry = last bit dropped.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] sh,
                                 input logic [2:0] m);
    exp_t        e;
    logic [31:0] r;
    int          s;
    bit          rot_ok;
    rot_ok = 1'b0;
`ifdef SHIFT_ROTATE_EN
    rot_ok = 1'b1;
`endif
    e.data = '0; e.carry = 1'b0; e.err = 1'b0;
    r = a;
    if (m > 3'd4 || (m >= 3'd3 && !rot_ok)) begin
      e.err = 1'b1;
    end else if (m >= 3'd3) begin
      s = int'(sh % 32);
      for (int i = 0; i < s; i++)
        r = (m == 3'd3) ? {r[30:0], r[31]} : {r[0], r[31:1]};
      e.data = r;
      if (s != 0) e.carry = (m == 3'd3) ? r[0] : r[31];
    end else if (sh >= 32) begin
      if (m == 3'd2) begin
        e.data  = {32{a[31]}};
        e.carry = a[31];
      end
    end else begin
      s = int'(sh);
      for (int i = 0; i < s; i++) begin
        case (m)
          3'd0:    begin e.carry = r[31]; r = {r[30:0], 1'b0}; end
          3'd1:    begin e.carry = r[0];  r = {1'b0, r[31:1]}; end
          default: begin e.carry = r[0];  r = {r[31], r[31:1]}; end
        endcase
      end
      e.data = r;
    end
    e.zero = (e.data == 32'd0);
    return e;
  endfunction

  function automatic logic [34:0] pack(input exp_t e);
    return {e.err, e.zero, e.carry, e.data};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout/unexpected event required none", name);
  endtask

  // Compare process: scoreboard, stall stability and full-pipe observation.
  logic        stall_prev = 1'b0;
  logic [35:0] held       = '0;
  logic        saw_full   = 1'b0;
  int          n_out      = 0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {out_valid, out_err, out_zero, out_carry, out_data}, held);
      if (out_valid) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          mon_e = sb[0];
          check("result", {out_err, out_zero, out_carry, out_data}, pack(mon_e));
          if (out_ready) begin
            void'(sb.pop_front());
            n_out++;
          end
        end
      end
      if (out_valid && !out_ready && !in_ready) saw_full = 1'b1;
      stall_prev = out_valid && !out_ready;
      held = {out_valid, out_err, out_zero, out_carry, out_data};
      if (in_valid && in_ready) sb.push_back(model(in_data, in_shamt, in_mode));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] sh, input logic [2:0] m,
                      output int acc);
    in_valid = 1'b1; in_data = a; in_shamt = sh; in_mode = m;
    acc = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) fail_now("send_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  logic [31:0] va [0:9] = '{32'h0000000F, 32'h80000001, 32'h80000000, 32'h12345678,
                            32'h00000001, 32'hDEADBEEF, 32'h80000001, 32'h7FFFFFFF,
                            32'hA5A5A5A5, 32'h0000F000};
  logic [31:0] vs [0:9] = '{32'd2, 32'd1, 32'd40, 32'd32, 32'd33, 32'd3, 32'd4,
                            32'hFFFFFFFF, 32'd0, 32'd31};
  logic [2:0]  vm [0:9] = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2, 3'd1, 3'd0};

  initial begin
    int acc;
    int seen;
    int out_before;
    int stale;
    exp_t e;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {in_ready, out_valid, out_err, out_zero, out_carry, out_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
    @(posedge clk); #1;

    // Hand-computed pins of the reference model
    e = model(32'h80000000, 32'd4, 3'd2);
    check("pin_sra4", pack(e), {1'b0, 1'b0, 1'b0, 32'hF8000000});
    e = model(32'h0000000F, 32'd2, 3'd1);
    check("pin_srl2", pack(e), {1'b0, 1'b0, 1'b1, 32'h00000003});
    e = model(32'h80000001, 32'd1, 3'd0);
    check("pin_sll1", pack(e), {1'b0, 1'b0, 1'b1, 32'h00000002});
    e = model(32'h80000000, 32'd40, 3'd2);
    check("pin_sra_sat", pack(e), {1'b0, 1'b0, 1'b1, 32'hFFFFFFFF});
    e = model(32'h12345678, 32'd32, 3'd0);
    check("pin_sll_sat", pack(e), {1'b0, 1'b1, 1'b0, 32'h00000000});
    e = model(32'h00000001, 32'd33, 3'd4);
`ifdef SHIFT_ROTATE_EN
    check("pin_ror33", pack(e), {1'b0, 1'b0, 1'b1, 32'h80000000});
`else
    check("pin_ror33", pack(e), {1'b1, 1'b1, 1'b0, 32'h00000000});
`endif
    e = model(32'hDEADBEEF, 32'd3, 3'd7);
    check("pin_mode7", pack(e), {1'b1, 1'b1, 1'b0, 32'h00000000});

    // First beat: exact latency and literal result
    send(32'h80000000, 32'd4, 3'd2, acc);
    seen = -1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) fail_now("latency_timeout");
    else begin
      check("latency", seen - acc, 2);
      check("sra4_out", {out_carry, out_zero, out_data}, {1'b0, 1'b0, 32'hF8000000});
    end
    wait_idle();

    // Directed table, back to back
    for (int i = 0; i < 10; i++) send(va[i], vs[i], vm[i], acc);
    wait_idle();

    // Backpressure: 6 beats, out_ready low on cycles 3..6
    saw_full   = 1'b0;
    out_before = n_out;
    fork
      begin
        send(32'h00000001, 32'd0,  3'd0, acc);
        send(32'h00000001, 32'd5,  3'd0, acc);
        send(32'hF0000000, 32'd8,  3'd2, acc);
        send(32'h0000FFFF, 32'd16, 3'd1, acc);
        send(32'h80000001, 32'd31, 3'd3, acc);
        send(32'h00000000, 32'd7,  3'd0, acc);
      end
      begin
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_idle();
    check("bp_count", n_out - out_before, 6);
    check("bp_in_ready_drop", saw_full, 1'b1);

    // Reset with two beats in flight
    send(32'h00000010, 32'd1, 3'd0, acc);
    send(32'h00000020, 32'd1, 3'd1, acc);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_state", {in_ready, out_valid, out_err, out_zero, out_carry, out_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", stale, 0);
    @(posedge clk); #1;

    // Recovery after reset
    send(32'h00000003, 32'd2, 3'd0, acc);
    wait_idle();
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
